// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, valid/ready handshakes on both sides, flush abort.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic [2:0]      i_func3,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  function automatic logic [XLEN-1:0] cneg1(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2:0]          func_q, func_d;
  logic                neg_q, neg_d;

  // Request decode: operand signedness, magnitudes and the one-cycle divide cases
  logic            is_div_i, a_sgn_i, b_sgn_i, a_neg_i, b_neg_i;
  logic [XLEN-1:0] a_mag_i, b_mag_i, special_res_i;
  logic            div_zero_i, div_ovf_i, special_i, accept;

  always_comb begin
    is_div_i   = i_func3[2];
    a_sgn_i    = is_div_i ? ~i_func3[0] : (i_func3[1:0] != 2'b11);
    b_sgn_i    = is_div_i ? ~i_func3[0] : ~i_func3[1];
    a_neg_i    = a_sgn_i & i_A[XLEN-1];
    b_neg_i    = b_sgn_i & i_B[XLEN-1];
    a_mag_i    = cneg1(a_neg_i, i_A);
    b_mag_i    = cneg1(b_neg_i, i_B);
    div_zero_i = is_div_i && (i_B == '0);
    div_ovf_i  = is_div_i && !i_func3[0] && (i_A == {1'b1, {(XLEN-1){1'b0}}}) && (i_B == '1);
    special_i  = div_zero_i || div_ovf_i;
    if (div_zero_i) special_res_i = i_func3[1] ? i_A : '1;
    else            special_res_i = i_func3[1] ? '0 : i_A;
    accept     = (state_q == S_IDLE) && i_valid && !i_flush;
  end

  // One iteration of either algorithm; acc holds {partial/remainder, multiplier/quotient}
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_diff, quo_fix, rem_fix;
  logic              div_ge;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[XLEN-1:0] - b_q;
    if (!func_q[2])  step = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_ge) step = {div_diff, acc_q[XLEN-2:0], 1'b1};
    else             step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod_fix = cneg2(neg_q, step);
    quo_fix  = cneg1(neg_q, step[XLEN-1:0]);
    rem_fix  = cneg1(neg_q, step[2*XLEN-1:XLEN]);
    if (!func_q[2]) final_res = (func_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else            final_res = func_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge i_clk) begin
    acc_q  <= acc_d;
    b_q    <= b_d;
    func_q <= func_d;
    neg_q  <= neg_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_valid) state_d = special_i ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        S_DONE: if (i_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    acc_d    = acc_q;
    b_d      = b_q;
    func_d   = func_q;
    neg_d    = neg_q;
    if (i_flush) begin
      cnt_d = '0;
    end else if (accept) begin
      acc_d  = {{XLEN{1'b0}}, a_mag_i};
      b_d    = b_mag_i;
      func_d = i_func3;
      neg_d  = (is_div_i && i_func3[1]) ? a_neg_i : (a_neg_i ^ b_neg_i);
      if (special_i) begin
        cnt_d    = '0;
        result_d = special_res_i;
      end else begin
        cnt_d = CNT_W'(XLEN);
      end
    end else if (state_q == S_CALC) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) result_d = final_res;
    end
  end

  always_comb begin
    o_ready  = (state_q == S_IDLE);
    o_valid  = (state_q == S_DONE);
    o_busy   = (state_q != S_IDLE);
    o_result = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at XLEN=32 and XLEN=16 with an expected-result scoreboard.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst_n, flush, rdy;
  logic        v32, v16;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic [2:0]  f32, f16;
  logic        ordy32, ovld32, obusy32, ordy16, ovld16, obusy16;
  logic [31:0] r32;
  logic [15:0] r16;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v32), .o_ready(ordy32),
    .i_A(a32), .i_B(b32), .i_func3(f32), .o_valid(ovld32), .i_ready(rdy),
    .o_result(r32), .o_busy(obusy32)
  );

  ex_muldiv #(.XLEN(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v16), .o_ready(ordy16),
    .i_A(a16), .i_B(b16), .i_func3(f16), .o_valid(ovld16), .i_ready(rdy),
    .o_result(r16), .o_busy(obusy16)
  );

  function automatic logic out_valid(input bit w16);
    return w16 ? ovld16 : ovld32;
  endfunction
  function automatic logic out_ready(input bit w16);
    return w16 ? ordy16 : ordy32;
  endfunction
  function automatic logic [31:0] out_result(input bit w16);
    return w16 ? {16'h0, r16} : r32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for the result, compare against the scoreboard, then handshake.
  task automatic do_op(input bit w16, input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    logic [31:0] e;
    int el;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    if (w16) begin v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; f16 = f; end
    else     begin v32 = 1'b1; a32 = a;       b32 = b;       f32 = f; end
    chk({tag, "_rdy"}, 32'(out_ready(w16)), 32'd1);
    @(posedge clk); n = 1;
    @(negedge clk); v16 = 1'b0; v32 = 1'b0;
    while (!out_valid(w16) && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, "_lat"}, 32'(n), 32'(el));
    chk(tag, out_result(w16), e);
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk); rdy = 1'b0;
    chk({tag, "_idle"}, {30'd0, out_valid(w16), out_ready(w16)}, 32'b01);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] e;
    rst_n = 1'b0; flush = 1'b0; rdy = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; f32 = '0;
    v16 = 1'b0; a16 = '0; b16 = '0; f16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst32", {28'd0, ovld32, ordy32, obusy32, 1'b0}, 32'b0100);
    chk("rst32_res", r32, 32'h0);
    chk("rst16", {28'd0, ovld16, ordy16, obusy16, 1'b0}, 32'b0100);

    // Multiply, 32-bit
    do_op(0, "mul",    3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    do_op(0, "mulhu",  3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
    do_op(0, "mulh",   3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    do_op(0, "mulhsu", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    do_op(0, "mulh_mm",3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    // Divide, 32-bit
    do_op(0, "div",    3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    do_op(0, "rem",    3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    do_op(0, "divu",   3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op(0, "remu",   3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op(0, "rem_pos_neg", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    // Special cases
    do_op(0, "div_z",   3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    do_op(0, "divu_z",  3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    do_op(0, "remu_z",  3'b111, 32'd5, 32'd0, 32'd5, 1);
    do_op(0, "div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op(0, "rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    do_op(0, "divu_big",3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);

    // Backpressure; requests presented in CALC/DONE must be ignored
    exp_q.push_back(32'd14);
    v32 = 1'b1; a32 = 32'd100; b32 = 32'd7; f32 = 3'b101;
    @(posedge clk); n = 1;
    @(negedge clk); a32 = 32'd5; b32 = 32'd0; f32 = 3'b100;
    chk("bp_calc_rdy", {31'd0, ordy32}, 32'd0);
    while (!ovld32 && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("bp_lat", 32'(n), 32'd33);
    chk("bp_res", r32, e);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_res", r32, e);
      chk("bp_hold_vr", {30'd0, ovld32, ordy32}, 32'b10);
    end
    v32 = 1'b0; rdy = 1'b1;
    @(posedge clk);
    @(negedge clk); rdy = 1'b0;
    chk("bp_release", {29'd0, ovld32, ordy32, obusy32}, 32'b010);

    // Flush mid-divide
    v32 = 1'b1; a32 = 32'd1000; b32 = 32'd7; f32 = 3'b101;
    @(posedge clk);
    @(negedge clk); v32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk);
    @(negedge clk); flush = 1'b0;
    chk("flush_state", {29'd0, ovld32, ordy32, obusy32}, 32'b010);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ovld32) seen = 1'b1;
    end
    chk("flush_novalid", {31'd0, seen}, 32'd0);
    do_op(0, "mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Request coinciding with flush in IDLE is dropped
    v32 = 1'b1; flush = 1'b1; a32 = 32'd9; b32 = 32'd9; f32 = 3'b000;
    @(posedge clk);
    @(negedge clk); v32 = 1'b0; flush = 1'b0;
    chk("flush_req_drop", {31'd0, obusy32}, 32'd0);

    // Reset mid-CALC
    v32 = 1'b1; a32 = 32'd123; b32 = 32'd45; f32 = 3'b000;
    @(posedge clk);
    @(negedge clk); v32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_mid", {29'd0, ovld32, ordy32, obusy32}, 32'b010);
    chk("rst_mid_res", r32, 32'h0);

    // XLEN = 16
    do_op(1, "w16_mulhu", 3'b011, 32'hFFFF, 32'hFFFF, 32'hFFFE, 17);
    do_op(1, "w16_mul",   3'b000, 32'd7, 32'hFFFD, 32'hFFEB, 17);
    do_op(1, "w16_mulh",  3'b001, 32'h8000, 32'h8000, 32'h4000, 17);
    do_op(1, "w16_div",   3'b100, 32'hFFF9, 32'd2, 32'hFFFD, 17);
    do_op(1, "w16_remu",  3'b111, 32'd100, 32'd7, 32'd2, 17);
    do_op(1, "w16_div_z", 3'b100, 32'd5, 32'd0, 32'hFFFF, 1);
    do_op(1, "w16_div_ovf", 3'b100, 32'h8000, 32'hFFFF, 32'h8000, 1);
    do_op(1, "w16_rem_ovf", 3'b110, 32'h8000, 32'hFFFF, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit for the EX stage that implements the full RV32M operation set. It is parametrised in operand width and sits beside the combinational EX ALU. It takes operands through a valid/ready handshake, runs a shift-add multiply or a restoring divide over multiple cycles, and holds the result until the pipeline accepts it. Flush support lets a mispredicted or excepting instruction abort an in-flight operation.

Parameters:
XLEN, 32, operand/result width in bits (power of 2, ≥8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_flush  input  1  abort current operation, return to IDLE
i_valid  input  1  request valid
o_ready  output  1  unit can accept a request
i_A  input  XLEN  operand rs1
i_B  input  XLEN  operand rs2
i_func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_result  output  XLEN  result
o_busy  output  1  high in CALC or DONE (hazard stall source)

Behaviour:
- Reset (i_rst_n=0 at clock edge): state=IDLE; o_valid=0, o_result=0, o_busy=0, counter=0; o_ready=1 after reset. Reset has priority over flush and handshakes.
- States: IDLE, CALC, DONE.
- IDLE: o_ready=1. i_valid=1 latches i_A, i_B and i_func3 (the accept edge).
  - Normal op → CALC with counter=XLEN.
  - Special divide case → DONE directly.
- CALC: o_ready=0. Each cycle performs one iteration and decrements the counter. At counter==1 the final iteration completes and the state moves to DONE.
  - o_valid rises exactly XLEN+1 cycles after the accept edge.
- DONE: o_valid=1; o_result is stable.
  - i_ready=1 → IDLE next cycle.
  - Otherwise hold; o_result and o_valid must not change while stalled.
  - o_ready=0 in DONE. There is no back-to-back accept in the same cycle as the result handshake.
- i_flush=1 (and not reset): next state=IDLE, o_valid=0, partial results discarded. A request presented in the same cycle as a flush is not accepted.
- Multiply:
  - Operands are converted to magnitude form. Signedness: MUL/MULH = signed×signed, MULHSU = signed×unsigned, MULHU = unsigned×unsigned.
  - Radix-2 shift-add into a 2·XLEN accumulator; the 2·XLEN product is negated at the end if the signs differ.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - MUL low half is identical for any signedness.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(A) XOR sign(B) for DIV.
  - Remainder sign = sign(A) for REM.
  - DIVU/REMU are fully unsigned.
- Special cases (1-cycle path: accept edge → DONE next cycle):
  - Divide by zero (B==0): DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A = −2^(XLEN−1), B = −1, DIV/REM only): DIV returns A; REM returns 0.
- o_busy = (state != IDLE).
- No exceptions or flags are produced.

Test Plan:
1. MUL A=7, B=−3 (0xFFFFFFFD): o_result=0xFFFFFFEB, with o_valid exactly 33 cycles after accept. MULHU with the same operands gives 0x00000006. MULH gives 0xFFFFFFFF.
2. MULHSU A=0x80000000, B=0xFFFFFFFF → 0x80000000. MULH A=B=0x80000000 → 0x40000000.
3. DIV A=−7, B=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU A=100, B=7 → 14; REMU → 2.
4. Special cases, each with o_valid one cycle after accept:
   - DIV A=5, B=0 → 0xFFFFFFFF; REMU A=5, B=0 → 5.
   - DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
5. Backpressure and handshake:
   - Hold i_ready=0 for 10 cycles in DONE → o_result stable and o_valid held high.
   - i_valid asserted during CALC/DONE is ignored (o_ready=0).
   - After i_ready=1 the unit is back in IDLE with o_ready=1 the next cycle.
6. Flush and reset:
   - Assert i_flush at iteration 10 of a DIVU → IDLE next cycle, o_valid never rises. A following MUL 3×4 returns 12.
   - Repeat with i_rst_n=0 mid-CALC → all outputs at reset values on the next edge.
   - Rerun cases 1–4 with XLEN=16, e.g. MULHU 0xFFFF×0xFFFF → 0xFFFE with 17-cycle latency.
